// File: rtl/psd_divide_pkg.sv
// Shared definitions for the psd_divide sequential divider.
package psd_divide_pkg;

  // Operand/result width.
  localparam int PSD_DATA_WIDTH = 32;

  // Number of non-restoring iterations: one quotient bit per clock.
  localparam int PSD_ITER_COUNT = PSD_DATA_WIDTH;

  // Iteration counter width. It holds 0..PSD_ITER_COUNT-1 with headroom.
  localparam int PSD_CNT_W = 6;

  // Divider control states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage : psd_divide_pkg

// File: rtl/psd_divide_step.sv
// A single combinational non-restoring division iteration.
// The {rem, q} pair is shifted left by one bit. The divisor is then subtracted
// when the old partial remainder is non-negative, and added when it is
// negative. The new quotient bit is the inverted sign of the new remainder.
module psd_divide_step
  import psd_divide_pkg::*;
#(
  parameter int W = PSD_DATA_WIDTH
) (
  input  logic [W:0]   i_rem,  // signed partial remainder (bit W is the sign)
  input  logic [W-1:0] i_q,    // quotient/dividend shift register
  input  logic [W-1:0] i_d,    // divisor
  output logic [W:0]   o_rem,  // next partial remainder
  output logic [W-1:0] o_q     // next quotient shift register
);

  logic [W:0] w_rem_sh;
  logic [W:0] w_d_ext;
  logic [W:0] w_rem_new;

  // Shift in the next dividend bit, then add or subtract the divisor
  // depending on the sign of the remainder before the shift.
  always_comb begin
    w_rem_sh = {i_rem[W-1:0], i_q[W-1]};
    w_d_ext  = {1'b0, i_d};
    if (!i_rem[W]) begin
      w_rem_new = w_rem_sh - w_d_ext;
    end else begin
      w_rem_new = w_rem_sh + w_d_ext;
    end
  end

  assign o_rem = w_rem_new;
  assign o_q   = {i_q[W-2:0], ~w_rem_new[W]};

endmodule : psd_divide_step

// File: rtl/psd_divide.sv
// Sequential non-restoring unsigned divider. It produces one quotient bit per
// clock, which takes DATA_WIDTH cycles in total.
//
// Control protocol: there is no valid/ready handshake. A rising edge with
// start=1 captures dividend/divisor and (re)starts a division from any
// state, which also aborts a division that is in flight. A rising edge with
// stop=1 copies Q and the sign-corrected remainder into the output
// registers. The result is exact once DATA_WIDTH edges have passed after the
// start edge. The controller is expected to count those cycles itself. When
// start and stop share an edge, the outputs capture the values from before
// that edge and the internal state restarts.
module psd_divide
  import psd_divide_pkg::*;
#(
  parameter int DATA_WIDTH = PSD_DATA_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,     // asynchronous, active-low
  input  logic                  start,
  input  logic                  stop,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] rest
);

  localparam logic [PSD_CNT_W-1:0] LAST_ITER = PSD_CNT_W'(DATA_WIDTH - 1);

  // Datapath and control state.
  logic [DATA_WIDTH:0]   r_rem;    // signed partial remainder
  logic [DATA_WIDTH-1:0] r_q;      // dividend in, quotient bits out
  logic [DATA_WIDTH-1:0] r_d;      // captured divisor
  logic [PSD_CNT_W-1:0]  r_cnt;    // iterations completed in this run
  state_e                r_state;

  // Output registers.
  logic [DATA_WIDTH-1:0] r_quotient;
  logic [DATA_WIDTH-1:0] r_rest;

  // Combinational results of one iteration and of the final correction.
  logic [DATA_WIDTH:0]   w_rem_next;
  logic [DATA_WIDTH-1:0] w_q_next;
  logic [DATA_WIDTH-1:0] w_rest_fix;

  psd_divide_step #(
    .W (DATA_WIDTH)
  ) u_step (
    .i_rem (r_rem),
    .i_q   (r_q),
    .i_d   (r_d),
    .o_rem (w_rem_next),
    .o_q   (w_q_next)
  );

  // A negative final remainder is one divisor too small. Adding D back
  // always lands in [0, D), so the low DATA_WIDTH bits are enough.
  always_comb begin
    if (r_rem[DATA_WIDTH]) begin
      w_rest_fix = r_rem[DATA_WIDTH-1:0] + r_d;
    end else begin
      w_rest_fix = r_rem[DATA_WIDTH-1:0];
    end
  end

  // Control FSM and datapath registers. start wins from any state. RUN
  // iterates DATA_WIDTH times. DONE and IDLE hold R/Q stable so that stop
  // can be repeated.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rem   <= '0;
      r_q     <= '0;
      r_d     <= '0;
      r_cnt   <= '0;
      r_state <= ST_IDLE;
    end else if (start) begin
      r_rem   <= '0;
      r_q     <= dividend;
      r_d     <= divisor;
      r_cnt   <= '0;
      r_state <= ST_RUN;
    end else begin
      case (r_state)
        ST_RUN: begin
          r_rem <= w_rem_next;
          r_q   <= w_q_next;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST_ITER) begin
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_state <= ST_DONE;
        end
        ST_IDLE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Output registers load only on stop. Outside DONE they carry partial
  // values, which is accepted silently.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_quotient <= '0;
      r_rest     <= '0;
    end else if (stop) begin
      r_quotient <= r_q;
      r_rest     <= w_rest_fix;
    end
  end

  assign quotient = r_quotient;
  assign rest     = r_rest;

endmodule : psd_divide

// File: tb/tb_psd_divide.sv
// Directed bench for psd_divide. Expected results are hand-computed, and a
// short random sweep is checked against the / and % operators.
module tb_psd_divide;

  // ---------------- clock / reset ----------------
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        stop  = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor  = '0;
  logic [31:0] quotient;
  logic [31:0] rest;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;   // rising edges at 5, 15, 25, ...

  psd_divide #(
    .DATA_WIDTH (32)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .stop     (stop),
    .dividend (dividend),
    .divisor  (divisor),
    .quotient (quotient),
    .rest     (rest)
  );

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [31:0] exp_q, input logic [31:0] exp_r);
    check({tag, " quotient"}, quotient, exp_q);
    check({tag, " rest"}, rest, exp_r);
  endtask

  // ---------------- driver tasks (enter and leave on a falling edge) ----------------
  task automatic wait_edges(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic pulse_start(input logic [31:0] a, input logic [31:0] b);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(negedge clock);
    start    = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    @(negedge clock);
    stop = 1'b0;
  endtask

  // start, 32 iteration edges, then stop on the following edge
  task automatic run_div(input logic [31:0] a, input logic [31:0] b);
    pulse_start(a, b);
    wait_edges(32);
    pulse_stop();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [31:0] ra;
    logic [31:0] rb;

    // Reset is low from time 0 and released at 23 ns, away from any clock edge.
    #2;
    check_out("reset", 32'h0, 32'h0);
    #21;
    reset = 1'b1;
    @(negedge clock);

    // A stop in IDLE right after reset returns the cleared Q and R.
    pulse_stop();
    check_out("idle_stop", 32'h0, 32'h0);

    run_div(32'h12345678, 32'h0BEEFEBA);
    check_out("basic", 32'h00000001, 32'h064557BE);

    // Outputs hold with no stop.
    wait_edges(5);
    check_out("hold_idle", 32'h00000001, 32'h064557BE);

    run_div(32'h00000000, 32'h0BEEFEBA);
    check_out("zero_dividend", 32'h00000000, 32'h00000000);

    run_div(32'h00000001, 32'h00000001);
    check_out("one_by_one", 32'h00000001, 32'h00000000);

    run_div(32'hFFFFFFFF, 32'h00000010);
    check_out("max_by_16", 32'h0FFFFFFF, 32'h0000000F);

    run_div(32'hFFFFFFFF, 32'hFFFFFFFF);
    check_out("max_by_max", 32'h00000001, 32'h00000000);

    run_div(32'h00000007, 32'h00000000);
    check_out("div_by_zero", 32'hFFFFFFFF, 32'h00000007);

    run_div(32'd100, 32'd7);
    check_out("100_by_7", 32'd14, 32'd2);

    run_div(32'h80000000, 32'h00000003);
    check_out("msb_by_3", 32'h2AAAAAAA, 32'h00000002);

    run_div(32'hDEADBEEF, 32'h00010000);
    check_out("deadbeef_by_64k", 32'h0000DEAD, 32'h0000BEEF);

    run_div(32'd5, 32'd10);
    check_out("small_by_large", 32'd0, 32'd5);

    // The outputs hold while a new division runs without stop. A restart in
    // RUN then produces only the new operands' result.
    pulse_start(32'hDEADBEEF, 32'h00000003);
    wait_edges(10);
    check_out("hold_run", 32'd0, 32'd5);
    pulse_start(32'd1000, 32'd10);
    wait_edges(32);
    pulse_stop();
    check_out("restart", 32'd100, 32'd0);

    // A repeated stop long after DONE gives the same result.
    wait_edges(20);
    pulse_stop();
    check_out("repeat_stop", 32'd100, 32'd0);

    // start and stop on one edge: the outputs take the finished 100/7, and
    // the new division then runs normally.
    pulse_start(32'd100, 32'd7);
    wait_edges(32);
    check_out("pre_same_edge", 32'd100, 32'd0);
    start    = 1'b1;
    stop     = 1'b1;
    dividend = 32'h12345678;
    divisor  = 32'h0BEEFEBA;
    @(negedge clock);
    start = 1'b0;
    stop  = 1'b0;
    check_out("same_edge", 32'd14, 32'd2);
    wait_edges(32);
    pulse_stop();
    check_out("after_same_edge", 32'h00000001, 32'h064557BE);

    // Reset mid-division at a 3 ns offset from the falling edge, held for
    // 2 cycles.
    pulse_start(32'hFFFFFFFF, 32'h00000010);
    wait_edges(10);
    #3;
    reset = 1'b0;
    #1;
    check_out("async_reset", 32'h0, 32'h0);
    #19;
    reset = 1'b1;
    @(negedge clock);
    pulse_stop();
    check_out("post_reset_idle", 32'h0, 32'h0);
    run_div(32'hFFFFFFFF, 32'h00000010);
    check_out("post_reset_div", 32'h0FFFFFFF, 32'h0000000F);

    // Random operands for toggle coverage, checked against / and %.
    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      if (i % 4 == 0) begin
        rb = 32'($urandom_range(1, 255));
      end else if (i % 4 == 1) begin
        rb = ra ^ 32'($urandom_range(0, 15));
      end else begin
        rb = $urandom;
      end
      if (rb == 32'h0) rb = 32'h1;
      run_div(ra, rb);
      check_out($sformatf("rand%0d", i), ra / rb, ra % rb);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_psd_divide
